// File: rtl/fme_pkg.sv
// fme_pkg: filter constants, FSM state encoding and output clipping shared by the
// fractional motion estimation half-pel interpolator.
package fme_pkg;

   localparam int TAPS = 8;
   localparam int COEF [TAPS] = '{-1, 4, -11, 40, 40, -11, 4, -1};

   // Single-pass (H or V) and two-pass (diagonal) normalisation
   localparam int ROUND_1 = 32;
   localparam int SHIFT_1 = 6;
   localparam int ROUND_2 = 2048;
   localparam int SHIFT_2 = 12;

   typedef enum logic [1:0] {
      IDLE,
      FILL,
      STREAM
   } state_t;

   // Saturate a signed value into the unsigned range 0..2^dw-1
   function automatic logic [31:0] clip(input logic signed [31:0] v, input int dw);
      logic signed [31:0] max_v;
      max_v = (32'sd1 <<< dw) - 32'sd1;
      if (v < 32'sd0)
         clip = 32'd0;
      else if (v > max_v)
         clip = max_v;
      else
         clip = v;
   endfunction

endpackage

// File: rtl/fme_fir8.sv
// fme_fir8: combinational 8-tap dot product with the HEVC half-pel luma coefficients.
// Inputs are zero- or sign-extended to the output width; the raw signed sum is returned.
module fme_fir8
   import fme_pkg::*;
#(
   parameter int IN_W      = 8,
   parameter bit IN_SIGNED = 1'b0,
   parameter int OUT_W     = 16
) (
   input  logic [TAPS*IN_W-1:0]    i_x,
   output logic signed [OUT_W-1:0] o_sum
);

   logic signed [OUT_W-1:0] w_acc;
   logic signed [OUT_W-1:0] w_ext;

   // multiply-accumulate across the eight taps, tap 0 at the lowest bits
   always_comb begin
      w_acc = '0;
      w_ext = '0;
      for (int t = 0; t < TAPS; t++) begin
         if (IN_SIGNED)
            w_ext = OUT_W'(signed'(i_x[t*IN_W +: IN_W]));
         else
            w_ext = OUT_W'(i_x[t*IN_W +: IN_W]);
         w_acc = w_acc + w_ext * OUT_W'(COEF[t]);
      end
   end

   assign o_sum = w_acc;

endmodule

// File: rtl/fme_interp_stream.sv
// fme_interp_stream: streaming half-pel interpolator. One reference row per handshake;
// a 7-row line buffer of integer samples and horizontal intermediates forms the 8-row
// window from which one row of H, V and diagonal predictions is produced per beat.
module fme_interp_stream
   import fme_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int BLOCK_W    = 8,
   parameter int BLOCK_H    = 8,
   parameter int INT_WIDTH  = 16
) (
   input  logic                              clock,
   input  logic                              reset,
   input  logic                              enable,
   input  logic                              in_valid,
   output logic                              in_ready,
   input  logic                              in_sop,
   input  logic [(BLOCK_W+7)*DATA_WIDTH-1:0] in_row,
   output logic                              out_valid,
   input  logic                              out_ready,
   output logic [BLOCK_W*DATA_WIDTH-1:0]     out_h,
   output logic [BLOCK_W*DATA_WIDTH-1:0]     out_v,
   output logic [BLOCK_W*DATA_WIDTH-1:0]     out_d,
   output logic                              out_last,
   output logic                              abort,
   output logic                              done
);

   localparam int LB_ROWS = TAPS - 1;
   localparam int MID_ROW = TAPS/2 - 1;
   localparam int PIX_W   = BLOCK_W*DATA_WIDTH;
   localparam int HROW_W  = BLOCK_W*INT_WIDTH;
   localparam int D_W     = INT_WIDTH + 8;
   localparam int CNT_W   = $clog2(BLOCK_H + TAPS);
   localparam logic [CNT_W-1:0] LAST_FILL = CNT_W'(TAPS - 2);
   localparam logic [CNT_W-1:0] LAST_ROW  = CNT_W'(BLOCK_H + TAPS - 2);

   // Round-to-nearest arithmetic right shift ahead of clipping
   function automatic logic signed [31:0] rnd_shift(input logic signed [31:0] v,
                                                    input int rnd, input int sh);
      rnd_shift = (v + 32'(rnd)) >>> sh;
   endfunction

   state_t             r_state;
   logic [CNT_W-1:0]   r_row;
   logic               r_out_valid;
   logic               r_out_last;
   logic               r_abort;
   logic               r_done;
   logic [PIX_W-1:0]   r_out_h;
   logic [PIX_W-1:0]   r_out_v;
   logic [PIX_W-1:0]   r_out_d;
   logic [PIX_W-1:0]   r_lb_int [LB_ROWS];
   logic [HROW_W-1:0]  r_lb_h   [LB_ROWS];

   logic               w_accept;
   logic [PIX_W-1:0]   w_new_int;
   logic [HROW_W-1:0]  w_new_h;
   logic [PIX_W-1:0]   w_pix_h;
   logic [PIX_W-1:0]   w_pix_v;
   logic [PIX_W-1:0]   w_pix_d;

   // In STREAM a row may only enter when the output register is free or draining
   assign in_ready  = reset & enable & ((r_state != STREAM) | ~r_out_valid | out_ready);
   assign w_accept  = in_valid & in_ready;
   assign w_new_int = in_row[3*DATA_WIDTH +: PIX_W];

   // ---- window -> H / V / D filters, one set per output lane ----
   genvar j, t;
   generate
      for (j = 0; j < BLOCK_W; j++) begin : g_lane
         logic [TAPS*DATA_WIDTH-1:0]  w_vcol;
         logic [TAPS*INT_WIDTH-1:0]   w_dcol;
         logic signed [INT_WIDTH-1:0] w_hsum;
         logic signed [INT_WIDTH-1:0] w_vsum;
         logic signed [D_W-1:0]       w_dsum;
         logic signed [INT_WIDTH-1:0] w_hmid;

         for (t = 0; t < LB_ROWS; t++) begin : g_tap
            assign w_vcol[t*DATA_WIDTH +: DATA_WIDTH] = r_lb_int[t][j*DATA_WIDTH +: DATA_WIDTH];
            assign w_dcol[t*INT_WIDTH +: INT_WIDTH]   = r_lb_h[t][j*INT_WIDTH +: INT_WIDTH];
         end
         assign w_vcol[LB_ROWS*DATA_WIDTH +: DATA_WIDTH] = w_new_int[j*DATA_WIDTH +: DATA_WIDTH];
         assign w_dcol[LB_ROWS*INT_WIDTH +: INT_WIDTH]   = w_new_h[j*INT_WIDTH +: INT_WIDTH];

         fme_fir8 #(.IN_W(DATA_WIDTH), .IN_SIGNED(1'b0), .OUT_W(INT_WIDTH)) u_fir_h (
            .i_x   (in_row[j*DATA_WIDTH +: TAPS*DATA_WIDTH]),
            .o_sum (w_hsum)
         );
         fme_fir8 #(.IN_W(DATA_WIDTH), .IN_SIGNED(1'b0), .OUT_W(INT_WIDTH)) u_fir_v (
            .i_x   (w_vcol),
            .o_sum (w_vsum)
         );
         fme_fir8 #(.IN_W(INT_WIDTH), .IN_SIGNED(1'b1), .OUT_W(D_W)) u_fir_d (
            .i_x   (w_dcol),
            .o_sum (w_dsum)
         );

         assign w_new_h[j*INT_WIDTH +: INT_WIDTH] = w_hsum;
         assign w_hmid = r_lb_h[MID_ROW][j*INT_WIDTH +: INT_WIDTH];

         assign w_pix_h[j*DATA_WIDTH +: DATA_WIDTH] =
            DATA_WIDTH'(clip(rnd_shift(32'(w_hmid), ROUND_1, SHIFT_1), DATA_WIDTH));
         assign w_pix_v[j*DATA_WIDTH +: DATA_WIDTH] =
            DATA_WIDTH'(clip(rnd_shift(32'(w_vsum), ROUND_1, SHIFT_1), DATA_WIDTH));
         assign w_pix_d[j*DATA_WIDTH +: DATA_WIDTH] =
            DATA_WIDTH'(clip(rnd_shift(32'(w_dsum), ROUND_2, SHIFT_2), DATA_WIDTH));
      end
   endgenerate

   // ---- line buffer: oldest row at index 0, newest accepted row at index 6 ----
   // shift every accepted row into the buffer; the oldest row drops out
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int k = 0; k < LB_ROWS; k++) begin
            r_lb_int[k] <= '0;
            r_lb_h[k]   <= '0;
         end
      end else if (w_accept) begin
         for (int k = 0; k < LB_ROWS-1; k++) begin
            r_lb_int[k] <= r_lb_int[k+1];
            r_lb_h[k]   <= r_lb_h[k+1];
         end
         r_lb_int[LB_ROWS-1] <= w_new_int;
         r_lb_h[LB_ROWS-1]   <= w_new_h;
      end
   end

   // ---- control FSM and output register ----
   // row sequencing, beat loading, abort on restart and done on last-beat transfer
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state     <= IDLE;
         r_row       <= '0;
         r_out_valid <= 1'b0;
         r_out_last  <= 1'b0;
         r_abort     <= 1'b0;
         r_done      <= 1'b0;
         r_out_h     <= '0;
         r_out_v     <= '0;
         r_out_d     <= '0;
      end else begin
         r_abort <= 1'b0;
         r_done  <= r_out_valid & out_ready & r_out_last;
         if (r_out_valid & out_ready) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
         end
         if (w_accept) begin
            if (in_sop) begin
               r_abort <= (r_state != IDLE);
               r_state <= FILL;
               r_row   <= CNT_W'(1);
            end else begin
               case (r_state)
                  FILL: begin
                     r_row <= r_row + CNT_W'(1);
                     if (r_row == LAST_FILL)
                        r_state <= STREAM;
                  end
                  STREAM: begin
                     r_out_h     <= w_pix_h;
                     r_out_v     <= w_pix_v;
                     r_out_d     <= w_pix_d;
                     r_out_valid <= 1'b1;
                     r_out_last  <= (r_row == LAST_ROW);
                     if (r_row == LAST_ROW) begin
                        r_state <= IDLE;
                        r_row   <= '0;
                     end else begin
                        r_row <= r_row + CNT_W'(1);
                     end
                  end
                  default: begin
                     r_state <= IDLE;
                  end
               endcase
            end
         end
      end
   end

   assign out_valid = r_out_valid;
   assign out_last  = r_out_last;
   assign out_h     = r_out_h;
   assign out_v     = r_out_v;
   assign out_d     = r_out_d;
   assign abort     = r_abort;
   assign done      = r_done;

endmodule
